esm_dwell_reporter: RTL and testbench



---
 rtl/esm_dwell_reporter_if.sv | 28 ++
 rtl/esm_dwell_reporter.sv | 220 ++++++++++++++++++++++
 tb/tb_esm_dwell_reporter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esm_dwell_reporter_if.sv
// Dwell metadata record, report framing constants and the AXI-stream bundle
// used by esm_dwell_reporter (master side) and the status DMA (slave side).

typedef struct packed {
    logic [15:0] tag;
    logic [15:0] frequency;
    logic [31:0] duration;
    logic [7:0]  gain;
    logic [7:0]  fast_lock_profile;
    logic [31:0] threshold_narrow;
    logic [31:0] threshold_wide;
    logic [63:0] channel_mask_narrow;
    logic [7:0]  channel_mask_wide;
} esm_dwell_metadata_t;

localparam logic [31:0] esm_control_magic_num                 = 32'hE5D0_5A1C;
localparam logic [7:0]  esm_module_id_dwell_controller        = 8'h02;
localparam logic [7:0]  esm_report_message_type_dwell_summary = 8'h10;

interface esm_dwell_reporter_if;
    logic        M_axis_valid;
    logic [31:0] M_axis_data;
    logic        M_axis_last;
    logic        M_axis_ready;

    modport master (output M_axis_valid, M_axis_data, M_axis_last, input  M_axis_ready);
    modport slave  (input  M_axis_valid, M_axis_data, M_axis_last, output M_axis_ready);
endinterface

// File: rtl/esm_dwell_reporter.sv
// Dwell-summary report transmitter: captures each enabled dwell and streams one framed report packet.
// Build option: define ESM_DWELL_REPORTER_TIMESTAMP_EN to append start/end timestamps (18-word packet).
module esm_dwell_reporter #(
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic                 Dwell_active,
    input  esm_dwell_metadata_t  Dwell_data,
    input  logic [31:0]          Dwell_sequence_num,
    input  logic [63:0]          Timestamp,
    esm_dwell_reporter_if.master m_axis
);

    if (AXI_DATA_WIDTH != 32) begin : g_width_check
        $error("esm_dwell_reporter supports AXI_DATA_WIDTH = 32 only");
    end

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
    localparam int N_WORDS = 18;
`else
    localparam int N_WORDS = 14;
`endif
    localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t              state_q;
    logic                dwell_active_q;
    logic                primed_q;
    logic                armed_q;
    logic                armed_d;
    logic [31:0]         act_cnt_q;
    logic [31:0]         act_cnt_d;
    esm_dwell_metadata_t cap_data_q;
    logic [31:0]         cap_seq_q;
    logic                pend_valid_q;
    esm_dwell_metadata_t pend_data_q;
    logic [31:0]         pend_seq_q;
    logic [31:0]         pend_cnt_q;
    esm_dwell_metadata_t tx_data_q;
    logic [31:0]         tx_seq_q;
    logic [31:0]         tx_cnt_q;
    logic [31:0]         tx_drop_q;
    logic [31:0]         tx_rpt_q;
    logic [31:0]         rpt_seq_q;
    logic [31:0]         drop_cnt_q;
    logic [4:0]          idx_q;
    logic [4:0]          idx_inc;
    logic [31:0]         word_nxt;
    logic                valid_q;
    logic                last_q;
    logic [31:0]         data_q;
    logic                dwell_rise;
    logic                dwell_fall;

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
    logic [63:0] cap_ts_q;
    logic [63:0] pend_ts_start_q;
    logic [63:0] pend_ts_end_q;
    logic [63:0] tx_ts_start_q;
    logic [63:0] tx_ts_end_q;
`else
    logic unused_timestamp;
    assign unused_timestamp = ^Timestamp;
`endif

    // primed_q masks the first post-reset cycle so a dwell already in progress is never armed.
    assign dwell_rise = primed_q & Dwell_active & ~dwell_active_q;
    assign dwell_fall = dwell_active_q & ~Dwell_active;
    assign idx_inc    = idx_q + 5'd1;

    assign m_axis.M_axis_valid = valid_q;
    assign m_axis.M_axis_data  = data_q;
    assign m_axis.M_axis_last  = last_q;

    // The rising-edge cycle itself counts as the first active cycle.
    always_comb begin
        armed_d   = armed_q;
        act_cnt_d = act_cnt_q;
        if (dwell_rise) begin
            armed_d   = Enable;
            act_cnt_d = '0;
        end else if (dwell_fall) begin
            armed_d = 1'b0;
        end
        if (Dwell_active && armed_d && (act_cnt_d != 32'hFFFF_FFFF)) begin
            act_cnt_d = act_cnt_d + 32'd1;
        end
    end

    always_comb begin
        word_nxt = '0;
        case (idx_inc)
            5'd1:  word_nxt = tx_rpt_q;
            5'd2:  word_nxt = {esm_module_id_dwell_controller, esm_report_message_type_dwell_summary, 16'h0000};
            5'd3:  word_nxt = tx_seq_q;
            5'd4:  word_nxt = {tx_data_q.frequency, tx_data_q.tag};
            5'd5:  word_nxt = tx_data_q.duration;
            5'd6:  word_nxt = {16'h0000, tx_data_q.fast_lock_profile, tx_data_q.gain};
            5'd7:  word_nxt = tx_data_q.threshold_narrow;
            5'd8:  word_nxt = tx_data_q.threshold_wide;
            5'd9:  word_nxt = tx_data_q.channel_mask_narrow[31:0];
            5'd10: word_nxt = tx_data_q.channel_mask_narrow[63:32];
            5'd11: word_nxt = {24'h0, tx_data_q.channel_mask_wide};
            5'd12: word_nxt = tx_cnt_q;
            5'd13: word_nxt = tx_drop_q;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
            5'd14: word_nxt = tx_ts_start_q[31:0];
            5'd15: word_nxt = tx_ts_start_q[63:32];
            5'd16: word_nxt = tx_ts_end_q[31:0];
            5'd17: word_nxt = tx_ts_end_q[63:32];
`endif
            default: word_nxt = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q        <= S_IDLE;
            dwell_active_q <= 1'b0;
            primed_q       <= 1'b0;
            armed_q        <= 1'b0;
            act_cnt_q      <= '0;
            cap_data_q     <= '0;
            cap_seq_q      <= '0;
            pend_valid_q   <= 1'b0;
            pend_data_q    <= '0;
            pend_seq_q     <= '0;
            pend_cnt_q     <= '0;
            tx_data_q      <= '0;
            tx_seq_q       <= '0;
            tx_cnt_q       <= '0;
            tx_drop_q      <= '0;
            tx_rpt_q       <= '0;
            rpt_seq_q      <= '0;
            drop_cnt_q     <= '0;
            idx_q          <= '0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            data_q         <= '0;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
            cap_ts_q        <= '0;
            pend_ts_start_q <= '0;
            pend_ts_end_q   <= '0;
            tx_ts_start_q   <= '0;
            tx_ts_end_q     <= '0;
`endif
        end else begin
            primed_q       <= 1'b1;
            dwell_active_q <= Dwell_active;
            armed_q        <= armed_d;
            act_cnt_q      <= act_cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (pend_valid_q) begin
                        pend_valid_q <= 1'b0;
                        tx_data_q    <= pend_data_q;
                        tx_seq_q     <= pend_seq_q;
                        tx_cnt_q     <= pend_cnt_q;
                        tx_drop_q    <= drop_cnt_q;
                        tx_rpt_q     <= rpt_seq_q;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
                        tx_ts_start_q <= pend_ts_start_q;
                        tx_ts_end_q   <= pend_ts_end_q;
`endif
                        idx_q   <= '0;
                        data_q  <= esm_control_magic_num;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (valid_q && m_axis.M_axis_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                            data_q    <= '0;
                            rpt_seq_q <= rpt_seq_q + 32'd1;
                            state_q   <= S_IDLE;
                        end else begin
                            idx_q  <= idx_inc;
                            data_q <= word_nxt;
                            last_q <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (dwell_rise && Enable) begin
                cap_data_q <= Dwell_data;
                cap_seq_q  <= Dwell_sequence_num;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
                cap_ts_q   <= Timestamp;
`endif
            end

            // The set below and the idle-state clear above are mutually exclusive on pend_valid_q.
            if (dwell_fall && armed_q) begin
                if (!pend_valid_q) begin
                    pend_valid_q <= 1'b1;
                    pend_data_q  <= cap_data_q;
                    pend_seq_q   <= cap_seq_q;
                    pend_cnt_q   <= act_cnt_q;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
                    pend_ts_start_q <= cap_ts_q;
                    pend_ts_end_q   <= Timestamp;
`endif
                end else if (drop_cnt_q != 32'hFFFF_FFFF) begin
                    drop_cnt_q <= drop_cnt_q + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_esm_dwell_reporter.sv
// Directed, table-driven bench for esm_dwell_reporter: stream monitor plus hand-computed packet checks.
module tb_esm_dwell_reporter;

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
    localparam int N_WORDS = 18;
`else
    localparam int N_WORDS = 14;
`endif
    localparam logic [31:0] TB_MAGIC = 32'hE5D0_5A1C;
    localparam logic [31:0] TB_W2    = 32'h0210_0000;

    typedef struct {
        logic [15:0] tag;
        logic [15:0] freq;
        logic [7:0]  gain;
        logic [7:0]  flp;
        int          len;
        logic [31:0] exp_w4;
        logic [31:0] exp_w6;
        logic [31:0] exp_w12;
    } vec_t;

    typedef struct {
        logic [31:0] w [18];
        int          len;
    } pkt_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                dwell_active;
    esm_dwell_metadata_t dwell_data;
    logic [31:0]         dwell_seq;
    logic [63:0]         cyc = '0;
    logic [63:0]         ts_base;
    logic [63:0]         timestamp;
    logic                ready_fixed;
    logic                rnd_mode;
    logic                rnd_bit = 1'b1;

    int checks = 0;
    int errors = 0;

    esm_dwell_reporter_if axis ();

    assign timestamp         = ts_base + cyc;
    assign axis.M_axis_ready = rnd_mode ? rnd_bit : ready_fixed;

    esm_dwell_reporter #(.AXI_DATA_WIDTH(32)) dut (
        .Clk               (clk),
        .Rst               (rst),
        .Enable            (enable),
        .Dwell_active      (dwell_active),
        .Dwell_data        (dwell_data),
        .Dwell_sequence_num(dwell_seq),
        .Timestamp         (timestamp),
        .m_axis            (axis)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    // Stream monitor: collects packets and tallies handshake-rule violations.
    pkt_t        pkts [$];
    pkt_t        mon_pkt;
    logic [31:0] cur [18];
    int          cur_len = 0;
    int          hold_viol = 0;
    int          last_viol = 0;
    int          stall_seen = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            cur_len = 0;
            pv      = 1'b0;
        end else begin
            if (pv && !pr) begin
                stall_seen++;
                if (axis.M_axis_valid !== 1'b1 || axis.M_axis_data !== pd || axis.M_axis_last !== pl)
                    hold_viol++;
            end
            if (axis.M_axis_valid && axis.M_axis_ready) begin
                if (cur_len < 18) cur[cur_len] = axis.M_axis_data;
                cur_len++;
                if (axis.M_axis_last !== (cur_len == N_WORDS)) last_viol++;
                if (axis.M_axis_last) begin
                    mon_pkt.w   = cur;
                    mon_pkt.len = cur_len;
                    pkts.push_back(mon_pkt);
                    $display("pkt %0d: %0d words rpt_seq=%0d dwell_seq=%08h cycles=%0d drops=%0d",
                             pkts.size() - 1, cur_len, cur[1], cur[3], cur[12], cur[13]);
                    cur_len = 0;
                end
            end
            pv = axis.M_axis_valid;
            pr = axis.M_axis_ready;
            pl = axis.M_axis_last;
            pd = axis.M_axis_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic esm_dwell_metadata_t make_meta(input int idx, input logic [15:0] tag,
                                                      input logic [15:0] freq, input logic [7:0] gain,
                                                      input logic [7:0] flp);
        esm_dwell_metadata_t m;
        m.tag                 = tag;
        m.frequency           = freq;
        m.duration            = 32'hD000_0000 | 32'(idx);
        m.gain                = gain;
        m.fast_lock_profile   = flp;
        m.threshold_narrow    = 32'h1000_0000 | 32'(idx);
        m.threshold_wide      = 32'h2000_0000 | 32'(idx);
        m.channel_mask_narrow = {32'h0123_4567 ^ 32'(idx), 32'h89AB_CDEF + 32'(idx)};
        m.channel_mask_wide   = 8'hA0 ^ 8'(idx);
        return m;
    endfunction

    function automatic esm_dwell_metadata_t auto_meta(input int idx);
        return make_meta(idx, 16'(idx * 3 + 1), 16'(idx + 256), 8'(idx), 8'(255 - idx));
    endfunction

    function automatic logic [31:0] exp_word(input esm_dwell_metadata_t m, input logic [31:0] dseq,
                                             input logic [31:0] rpt, input logic [31:0] cnt,
                                             input logic [31:0] drop, input int k);
        case (k)
            0:  return TB_MAGIC;
            1:  return rpt;
            2:  return TB_W2;
            3:  return dseq;
            4:  return {m.frequency, m.tag};
            5:  return m.duration;
            6:  return {16'h0000, m.fast_lock_profile, m.gain};
            7:  return m.threshold_narrow;
            8:  return m.threshold_wide;
            9:  return m.channel_mask_narrow[31:0];
            10: return m.channel_mask_narrow[63:32];
            11: return {24'h0, m.channel_mask_wide};
            12: return cnt;
            13: return drop;
            default: return 32'h0;
        endcase
    endfunction

    int rd_idx = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_dwell(input esm_dwell_metadata_t m, input logic [31:0] s, input int len);
        dwell_data   = m;
        dwell_seq    = s;
        enable       = 1'b1;
        dwell_active = 1'b1;
        idle(len);
        dwell_active = 1'b0;
    endtask

    task automatic wait_pkt(input string nm, output pkt_t p, output bit ok);
        int c;
        c = 0;
        while (rd_idx >= pkts.size() && c < 3000) begin
            idle(1);
            c++;
        end
        ok = (rd_idx < pkts.size());
        if (ok) begin
            p = pkts[rd_idx];
            rd_idx++;
        end else begin
            chk({nm, "_arrived"}, 64'(pkts.size()), 64'(rd_idx + 1));
        end
    endtask

    task automatic check_pkt(input string nm, input esm_dwell_metadata_t m, input logic [31:0] dseq,
                             input logic [31:0] rpt, input logic [31:0] cnt, input logic [31:0] drop,
                             output pkt_t p);
        bit ok;
        wait_pkt(nm, p, ok);
        if (ok) begin
            chk({nm, "_len"}, 64'(p.len), 64'(N_WORDS));
            for (int k = 0; k < 14; k++)
                chk($sformatf("%s_w%0d", nm, k), p.w[k], exp_word(m, dseq, rpt, cnt, drop, k));
        end
    endtask

    vec_t                vecs [4];
    esm_dwell_metadata_t m;
    pkt_t                p;
    logic [31:0]         rpt;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 8'h11, 8'h22, 100, 32'h5678_1234, 32'h0000_2211, 32'd100};
        vecs[1] = '{16'hFFFF, 16'h0000, 8'hFF, 8'h00, 1,   32'h0000_FFFF, 32'h0000_00FF, 32'd1};
        vecs[2] = '{16'h0001, 16'h8000, 8'h00, 8'hA5, 7,   32'h8000_0001, 32'h0000_A500, 32'd7};
        vecs[3] = '{16'hBEEF, 16'hCAFE, 8'h5A, 8'h3C, 33,  32'hCAFE_BEEF, 32'h0000_3C5A, 32'd33};

        rst          = 1'b1;
        enable       = 1'b0;
        dwell_active = 1'b0;
        dwell_data   = '0;
        dwell_seq    = '0;
        ts_base      = '0;
        ready_fixed  = 1'b1;
        rnd_mode     = 1'b0;
        idle(3);
        chk("reset_valid", axis.M_axis_valid, 0);
        chk("reset_last",  axis.M_axis_last,  0);
        chk("reset_data",  axis.M_axis_data,  0);
        rst = 1'b0;
        idle(2);
        rpt = 0;

        // Table: single dwells with ready held high, incl. the 1-cycle dwell.
        for (int i = 0; i < 4; i++) begin
            m = make_meta(i, vecs[i].tag, vecs[i].freq, vecs[i].gain, vecs[i].flp);
            run_dwell(m, 32'hA000_0000 + 32'(i), vecs[i].len);
            if (i == 0) begin
                idle(1);
                chk("latency_e0_valid", axis.M_axis_valid, 0);
                idle(1);
                chk("latency_e1_valid", axis.M_axis_valid, 1);
                chk("latency_e1_data",  axis.M_axis_data,  TB_MAGIC);
                chk("latency_e1_last",  axis.M_axis_last,  0);
            end
            check_pkt($sformatf("vec%0d", i), m, 32'hA000_0000 + 32'(i), rpt, 32'(vecs[i].len), 0, p);
            chk($sformatf("vec%0d_tbl_w4", i),  p.w[4],  vecs[i].exp_w4);
            chk($sformatf("vec%0d_tbl_w6", i),  p.w[6],  vecs[i].exp_w6);
            chk($sformatf("vec%0d_tbl_w12", i), p.w[12], vecs[i].exp_w12);
            rpt++;
            idle(3);
        end

        // Random ready throttling after a fresh reset: report sequence restarts at 0.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        rpt = 0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m = auto_meta(60 + i);
            run_dwell(m, 32'hB000_0000 + 32'(i), 3 + i);
            check_pkt($sformatf("thr%0d", i), m, 32'hB000_0000 + 32'(i), rpt, 32'(3 + i), 0, p);
            rpt++;
        end
        rnd_mode = 1'b0;
        chk("throttle_stalls_seen", 64'(stall_seen > 0), 1);
        idle(3);

        // Ready low across three dwells: third one is dropped.
        ready_fixed = 1'b0;
        run_dwell(auto_meta(20), 32'hC000_0000, 4);
        idle(3);
        run_dwell(auto_meta(21), 32'hC000_0001, 4);
        idle(3);
        run_dwell(auto_meta(22), 32'hC000_0002, 4);
        idle(5);
        chk("drop_held_pkts",   64'(pkts.size() - rd_idx), 0);
        chk("drop_held_valid",  axis.M_axis_valid, 1);
        chk("drop_held_data",   axis.M_axis_data,  TB_MAGIC);
        ready_fixed = 1'b1;
        check_pkt("dropA", auto_meta(20), 32'hC000_0000, rpt, 4, 0, p);
        rpt++;
        check_pkt("dropB", auto_meta(21), 32'hC000_0001, rpt, 4, 1, p);
        rpt++;
        idle(40);
        chk("drop_no_third_pkt", 64'(pkts.size() - rd_idx), 0);
        run_dwell(auto_meta(23), 32'hC000_0003, 5);
        check_pkt("dropD", auto_meta(23), 32'hC000_0003, rpt, 5, 1, p);
        rpt++;
        idle(3);

        // Enable low at the rising edge, raised mid-dwell: ignored.
        dwell_data   = auto_meta(40);
        dwell_seq    = 32'hD000_0000;
        enable       = 1'b0;
        dwell_active = 1'b1;
        idle(3);
        enable = 1'b1;
        idle(5);
        dwell_active = 1'b0;
        idle(30);
        chk("en_no_pkt",    64'(pkts.size() - rd_idx), 0);
        chk("en_valid_low", axis.M_axis_valid, 0);
        run_dwell(auto_meta(41), 32'hD000_0001, 6);
        check_pkt("en_next", auto_meta(41), 32'hD000_0001, rpt, 6, 1, p);
        rpt++;
        idle(3);

        // Async reset while word 6 is on the bus.
        m = auto_meta(50);
        run_dwell(m, 32'hE000_0000, 5);
        begin
            int c;
            c = 0;
            while (axis.M_axis_valid !== 1'b1 && c < 20) begin
                idle(1);
                c++;
            end
        end
        chk("rst_pkt_started", axis.M_axis_valid, 1);
        idle(6);
        chk("rst_at_word6", axis.M_axis_data, exp_word(m, 32'hE000_0000, rpt, 5, 1, 6));
        rst = 1'b1;
        #1;
        chk("rst_async_valid", axis.M_axis_valid, 0);
        chk("rst_async_last",  axis.M_axis_last,  0);
        chk("rst_async_data",  axis.M_axis_data,  0);
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("rst_no_partial_pkt", 64'(pkts.size() - rd_idx), 0);
        rpt = 0;
        run_dwell(auto_meta(51), 32'hE000_0001, 9);
        check_pkt("rst_next", auto_meta(51), 32'hE000_0001, rpt, 9, 0, p);
        rpt++;
        idle(3);

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
        // Start timestamp 0x1_00000010 sampled on the rising edge; end is 50 cycles later.
        ts_base = 64'h1_0000_0010 - cyc;
        run_dwell(auto_meta(70), 32'hF000_0000, 50);
        check_pkt("ts", auto_meta(70), 32'hF000_0000, rpt, 50, 0, p);
        chk("ts_w14_start_lo", p.w[14], 32'h0000_0010);
        chk("ts_w15_start_hi", p.w[15], 32'h0000_0001);
        chk("ts_w16_end_lo",   p.w[16], 32'h0000_0042);
        chk("ts_w17_end_hi",   p.w[17], 32'h0000_0001);
        rpt++;
        idle(3);
`endif

        chk("hold_violations", 64'(hold_viol), 0);
        chk("last_violations", 64'(last_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
